// File: rtl/lcd_frame_writer.sv
// LCD pixel-stream sink: maps color indices through BGP, packs four shades per
// byte and writes whole 160x144 frames into a double-buffered frame RAM.
module lcd_frame_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic [7:0]  bgp,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        fb_we,
  output logic        front_bank,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err
);

  localparam int unsigned LINE_PIXELS = 160;
  localparam int unsigned FRAME_LINES = 144;
  localparam int unsigned ROW_BYTES   = 40;
  localparam int unsigned XW          = 8;
  localparam int unsigned YW          = 8;
  localparam int unsigned OFFW        = 13;
  localparam int unsigned AW          = 14;
  localparam int unsigned DW          = 8;
  localparam int unsigned PACKW       = 6;

  logic [XW-1:0]    x_q, x_d, x_acc;
  logic [YW-1:0]    y_q, y_d;
  logic [OFFW-1:0]  row_base_q, row_base_d;
  logic [PACKW-1:0] pack_q, pack_d, pack_acc;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             front_bank_q, front_bank_d;
  logic             frame_done_q, frame_done_d;
  logic             line_err_q, line_err_d;
  logic             frame_err_q, frame_err_d;
  logic             fb_we_q, fb_we_d;
  logic [AW-1:0]    fb_addr_q, fb_addr_d;
  logic [DW-1:0]    fb_wdata_q, fb_wdata_d;

  logic [1:0]       shade;
  logic             accept;
  logic             line_end;
  logic             frame_end;
  logic             back;
  logic             line_full;
  logic             frame_full;

  // Palette lookup uses bgp as presented in the same cycle as the pixel
  always_comb begin
    case (lcd_color)
      2'd0:    shade = bgp[1:0];
      2'd1:    shade = bgp[3:2];
      2'd2:    shade = bgp[5:4];
      default: shade = bgp[7:6];
    endcase
  end

  assign back       = ~front_bank_q;
  assign line_end   = lcd_hsync & ~hsync_q & ~lcd_vsync;
  assign frame_end  = lcd_vsync & ~vsync_q;
  assign line_full  = (x_q == XW'(LINE_PIXELS));
  assign frame_full = (y_q == YW'(FRAME_LINES));
  // Pixels past the last line would address outside the bank, so they drop too
  assign accept     = lcd_pixel & ~lcd_vsync & ~line_full & ~frame_full;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    pack_d       = pack_q;
    hsync_d      = lcd_hsync;
    vsync_d      = lcd_vsync;
    front_bank_d = front_bank_q;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    x_acc        = x_q;
    pack_acc     = pack_q;

    if (lcd_pixel && !accept) begin
      line_err_d = 1'b1;
    end

    if (accept) begin
      pack_acc = {pack_q[PACKW-3:0], shade};
      if (x_q[1:0] == 2'd3) begin
        fb_we_d    = 1'b1;
        fb_addr_d  = {back, row_base_q + OFFW'(x_q[XW-1:2])};
        fb_wdata_d = {pack_q, shade};
      end
      x_acc = x_q + XW'(1);
    end
    x_d    = x_acc;
    pack_d = pack_acc;

    // Line end sees the x that already includes a same-cycle pixel
    if (line_end) begin
      if (frame_full) begin
        line_err_d = 1'b1;
      end else begin
        if (x_acc[1:0] != 2'd0) begin
          fb_we_d   = 1'b1;
          fb_addr_d = {back, row_base_q + OFFW'(x_acc[XW-1:2])};
          case (x_acc[1:0])
            2'd1:    fb_wdata_d = {pack_acc[1:0], 6'b0};
            2'd2:    fb_wdata_d = {pack_acc[3:0], 4'b0};
            default: fb_wdata_d = {pack_acc, 2'b0};
          endcase
        end
        if (x_acc != XW'(LINE_PIXELS)) begin
          line_err_d = 1'b1;
        end
        x_d        = '0;
        y_d        = y_q + YW'(1);
        row_base_d = row_base_q + OFFW'(ROW_BYTES);
        pack_d     = '0;
      end
    end

    if (frame_end) begin
      if (frame_full) begin
        front_bank_d = back;
        frame_done_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
      pack_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q          <= '0;
      y_q          <= '0;
      row_base_q   <= '0;
      pack_q       <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      front_bank_q <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      row_base_q   <= row_base_d;
      pack_q       <= pack_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      front_bank_q <= front_bank_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign front_bank = front_bank_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Scoreboard bench for lcd_frame_writer: a line-level model predicts frame RAM
// writes and bank handovers; a monitor compares them as the DUT emits them.
module tb_lcd_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_pixel;
  logic [1:0]  lcd_color;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic [7:0]  bgp;
  logic [13:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_we;
  logic        front_bank;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;

  always #5 clk = ~clk;

  lcd_frame_writer dut (
    .clk        (clk),
    .rst        (rst),
    .lcd_pixel  (lcd_pixel),
    .lcd_color  (lcd_color),
    .lcd_hsync  (lcd_hsync),
    .lcd_vsync  (lcd_vsync),
    .bgp        (bgp),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_we      (fb_we),
    .front_bank (front_bank),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  wq[$];
  logic fdq[$];
  int   errors = 0;
  int   checks = 0;

  int   m_y;
  logic m_front;
  logic m_line_err;
  logic m_frame_err;

  logic [1:0] col_a[0:199];
  logic [7:0] pal_a[0:199];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Monitor: every write strobe and every frame_done pulse must match the queue head
  always @(negedge clk) begin
    if (rst) begin
      if (fb_we) begin
        if (wq.size() == 0) begin
          fail_event("unexpected_write", {18'b0, fb_addr});
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("fb_addr", {18'b0, fb_addr}, {18'b0, w.addr});
          check("fb_wdata", {24'b0, fb_wdata}, {24'b0, w.data});
        end
      end
      if (frame_done) begin
        if (fdq.size() == 0) begin
          fail_event("unexpected_frame_done", {31'b0, front_bank});
        end else begin
          logic e;
          e = fdq.pop_front();
          check("front_bank_at_done", {31'b0, front_bank}, {31'b0, e});
        end
      end
    end
  end

  // Reference: a line of n pixels becomes ceil(min(n,160)/4) packed bytes
  task automatic model_line(input int n);
    int acc;
    int nb;
    if (m_y >= 144) begin
      m_line_err = 1'b1;
      return;
    end
    acc = (n > 160) ? 160 : n;
    nb  = (acc + 3) / 4;
    for (int k = 0; k < nb; k++) begin
      int  v;
      wr_t w;
      v = 0;
      for (int j = 0; j < 4; j++) begin
        int i;
        int s;
        i = 4 * k + j;
        s = 0;
        if (i < acc) s = (int'(pal_a[i]) >> (2 * int'(col_a[i]))) & 3;
        v = v * 4 + s;
      end
      w.addr = {~m_front, 13'(m_y * 40 + k)};
      w.data = 8'(v);
      wq.push_back(w);
    end
    if (n != 160) m_line_err = 1'b1;
    m_y++;
  endtask

  task automatic model_vsync();
    if (m_y == 144) begin
      m_front = ~m_front;
      fdq.push_back(m_front);
    end else begin
      m_frame_err = 1'b1;
    end
    m_y = 0;
  endtask

  task automatic model_reset();
    wq.delete();
    fdq.delete();
    m_y         = 0;
    m_front     = 1'b0;
    m_line_err  = 1'b0;
    m_frame_err = 1'b0;
  endtask

  // mode 0: colors 0,1,2,3 with E4; mode 1: color 0 with 1B; mode 2: random
  task automatic fill(input int mode);
    for (int i = 0; i < 200; i++) begin
      case (mode)
        0: begin col_a[i] = 2'(i % 4); pal_a[i] = 8'hE4; end
        1: begin col_a[i] = 2'd0; pal_a[i] = 8'h1B; end
        default: begin col_a[i] = 2'($urandom_range(3)); pal_a[i] = 8'($urandom); end
      endcase
    end
  endtask

  task automatic drive_line(input int n, input bit same_cycle, input bit do_end, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(7) == 0) begin
        @(posedge clk); #1;
        lcd_pixel = 1'b0;
        bgp       = 8'($urandom);
      end
      @(posedge clk); #1;
      lcd_pixel = 1'b1;
      lcd_color = col_a[i];
      bgp       = pal_a[i];
      if (same_cycle && i == n - 1) lcd_hsync = 1'b1;
    end
    @(posedge clk); #1;
    lcd_pixel = 1'b0;
    lcd_color = 2'($urandom_range(3));
    bgp       = 8'($urandom);
    if (do_end) begin
      lcd_hsync = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      lcd_hsync = 1'b0;
    end
  endtask

  task automatic drive_vsync();
    @(posedge clk); #1;
    lcd_vsync = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    lcd_vsync = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_flags(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_line_err"}, {31'b0, line_err}, {31'b0, m_line_err});
    check({tag, "_frame_err"}, {31'b0, frame_err}, {31'b0, m_frame_err});
    check({tag, "_front_bank"}, {31'b0, front_bank}, {31'b0, m_front});
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_fb_we"}, {31'b0, fb_we}, 32'd0);
    check({tag, "_fb_addr"}, {18'b0, fb_addr}, 32'd0);
    check({tag, "_fb_wdata"}, {24'b0, fb_wdata}, 32'd0);
    check({tag, "_front_bank"}, {31'b0, front_bank}, 32'd0);
    check({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
    check({tag, "_line_err"}, {31'b0, line_err}, 32'd0);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    lcd_pixel = 1'b0;
    lcd_color = 2'd0;
    lcd_hsync = 1'b0;
    lcd_vsync = 1'b0;
    bgp       = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Full frame, E4 palette, colors 0..3 repeating
    for (int l = 0; l < 144; l++) begin
      fill(0);
      model_line(160);
      drive_line(160, 1'b0, 1'b1, 1'b0);
    end
    model_vsync();
    drive_vsync();
    check_flags("frame_a");

    // Reset in the middle of a line after two pixels: no write may appear
    fill(2);
    drive_line(2, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    check_reset_outputs("midline_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Full frame after reset, palette 1B with color 0, random pixel gaps
    for (int l = 0; l < 144; l++) begin
      fill(1);
      model_line(160);
      drive_line(160, 1'b0, 1'b1, 1'b1);
    end
    model_vsync();
    drive_vsync();
    check_flags("frame_b");

    // Short line, next line, overflow line, same-cycle line, then random lines
    fill(2);
    model_line(158);
    drive_line(158, 1'b0, 1'b1, 1'b0);
    check_flags("short_line");
    fill(2);
    model_line(160);
    drive_line(160, 1'b0, 1'b1, 1'b1);
    fill(2);
    model_line(161);
    drive_line(161, 1'b0, 1'b1, 1'b0);
    fill(2);
    model_line(160);
    drive_line(160, 1'b1, 1'b1, 1'b0);
    for (int l = 4; l < 100; l++) begin
      int  n;
      bit  sc;
      fill(2);
      n  = ($urandom_range(3) == 0) ? 153 + $urandom_range(8) : 160;
      sc = ($urandom_range(1) == 1);
      model_line(n);
      drive_line(n, sc, 1'b1, 1'b1);
    end
    model_vsync();
    drive_vsync();
    check_flags("premature_vsync");

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("writes_drained", wq.size(), 32'd0);
    check("frame_done_drained", fdq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
